ram_latency_model: RTL and testbench
====================================

// Module: ram_latency_model
// PURPOSE
//  Responder end of the RAM port driven by the memory controller arbiter: accepts ramREN/ramWEN/ramaddr/ramstore,
//  reports progress on ramstate (ramstate_t from cpu_types_pkg: FREE/BUSY/ACCESS/ERROR) and returns ramload.
//  Word-addressed storage array with programmable access latency; stands in for the system RAM in simulation
//  and FPGA builds so the controller's iwait/dwait arbitration is exercised under realistic multi-cycle delays.
// PARAMETERS
//  LAT     2    BUSY cycles before ACCESS, counted from first cycle a request is seen; legal 1..15
//  ADDR_W  10   word-index width; DEPTH = 2**ADDR_W words of 32 bits (word_t)
// PORTS
//  CLK        in   1   clock; all state updates on rising edge
//  RST        in   1   reset, synchronous, active-high
//  ramREN     in   1   read request
//  ramWEN     in   1   write request
//  ramaddr    in   32  byte address; word index = ramaddr[ADDR_W+1:2], bits [1:0] ignored
//  ramstore   in   32  write data
//  ramload    out  32  read data; valid only when ramstate==ACCESS for a read, else 32'h0
//  ramstate   out  2   ramstate_t response state
//  naccess    out  32  count of completed ACCESS cycles (reads + writes)
// BEHAVIOUR
//  Internal FSM IDLE/WAIT/DONE, 4-bit down-counter cnt, latched request {lren,lwen,laddr}.
//  req = ramREN^ramWEN; bad = (ramREN&ramWEN) | (req & |ramaddr[31:ADDR_W+2]).
//  "changed" = in WAIT/DONE, {ramREN,ramWEN,ramaddr} != latched {lren,lwen,laddr}.
//  ramstate (combinational): bad -> ERROR (overrides all); IDLE: req?BUSY:FREE; WAIT: BUSY;
//   DONE: changed?BUSY:ACCESS.
//  IDLE: bad or !req -> stay. req -> latch request; LAT==1 ? ->DONE : cnt<=LAT-2, ->WAIT.
//  WAIT: bad -> IDLE, nothing latched. !req -> IDLE (abort). changed -> relatch, cnt reload as from IDLE,
//   stay WAIT (or ->DONE if LAT==1). cnt==0 -> DONE, else cnt<=cnt-1.
//  DONE: bad -> IDLE, no write. changed & req -> relatch, restart as from IDLE. !req -> IDLE, no write.
//   otherwise (ACCESS reported): write lwen -> mem[laddr]<=ramstore at this edge; naccess<=naccess+1; ->IDLE.
//  Latency: request first seen at cycle 0 -> ACCESS in cycle LAT exactly, if held stable.
//  Back-to-back: after ACCESS, FSM is IDLE next cycle; a request present then is cycle 0 of a new access
//   (one BUSY minimum between consecutive ACCESS cycles, even to same address).
//  Read in ACCESS returns mem contents as of the start of that cycle (no bypass needed; one access at a time).
//  naccess wraps 32'hFFFF_FFFF -> 0.
//  Reset: FSM<=IDLE, cnt<=0, latched request<=0, naccess<=0; outputs then ramstate=FREE (if no req),
//   ramload=0, naccess=0. Memory array NOT cleared. RST mid-access aborts it; no write occurs on a reset edge.
// TESTING
//  1 LAT=2, read addr 0x40 held: cycles 0,1 BUSY, cycle 2 ACCESS with ramload=mem[16]; then FREE when REN drops.
//  2 Write 0x40 data 0xDEADBEEF held to ACCESS, then read 0x40 -> ACCESS ramload=0xDEADBEEF; naccess=2.
//  3 ramREN=ramWEN=1 -> ERROR same cycle, no state change, no write, naccess unchanged; drop WEN -> read
//    starts, ACCESS LAT cycles later.
//  4 Read 0x40, change ramaddr to 0x44 in cycle 1 -> BUSY restarts, ACCESS at cycle 1+LAT with mem[17];
//    write aborted at DONE (WEN dropped) -> mem unchanged.
//  5 ramaddr=1<<(ADDR_W+2) with REN -> ERROR; RST asserted during WAIT of a write -> FREE next cycle,
//    target word retains old value, naccess=0.
//  6 LAT=1 and LAT=15 builds: ACCESS in cycle 1 / cycle 15; back-to-back reads give ACCESS every LAT+1 cycles.

Source files
------------

// File: rtl/ram_latency_model.sv
// Word-addressed RAM responder: a request held stable reaches ACCESS exactly LAT cycles after it is first seen.
// No backpressure of its own; the requester holds ramREN/ramWEN/ramaddr until ACCESS, and any change restarts the wait.
module ram_latency_model #(
  parameter int LAT    = 2,
  parameter int ADDR_W = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate,
  output logic [31:0] naccess
);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;
  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        lren_q, lren_d;
  logic        lwen_q, lwen_d;
  logic [31:0] laddr_q, laddr_d;
  logic [31:0] naccess_q, naccess_d;
  logic        req, bad, changed, start, mem_we;
  logic [ADDR_W-1:0] lidx;
  logic [31:0] mem [DEPTH];

  assign lidx = laddr_q[ADDR_W+1:2];

  always_comb begin
    req     = ramREN ^ ramWEN;
    bad     = (ramREN & ramWEN) | (req & (|ramaddr[31:ADDR_W+2]));
    changed = (state_q != S_IDLE) &&
              ({ramREN, ramWEN, ramaddr} != {lren_q, lwen_q, laddr_q});
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lren_d    = lren_q;
    lwen_d    = lwen_q;
    laddr_d   = laddr_q;
    naccess_d = naccess_q;
    mem_we    = 1'b0;
    start     = 1'b0;
    ramstate  = FREE;
    case (state_q)
      S_IDLE: begin
        ramstate = req ? BUSY : FREE;
        if (!bad && req) start = 1'b1;
      end
      S_WAIT: begin
        ramstate = BUSY;
        if (bad || !req)       state_d = S_IDLE;
        else if (changed)      start   = 1'b1;
        else if (cnt_q == 4'd0) state_d = S_DONE;
        else                   cnt_d   = cnt_q - 4'd1;
      end
      S_DONE: begin
        ramstate = changed ? BUSY : ACCESS;
        if (bad || !req)  state_d = S_IDLE;
        else if (changed) start   = 1'b1;
        else begin
          mem_we    = lwen_q;
          naccess_d = naccess_q + 32'd1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A (re)started request counts its first cycle as cycle 0 of the latency.
    if (start) begin
      lren_d  = ramREN;
      lwen_d  = ramWEN;
      laddr_d = ramaddr;
      if (LAT == 1) begin
        state_d = S_DONE;
        cnt_d   = 4'd0;
      end else begin
        state_d = S_WAIT;
        cnt_d   = CNT_INIT;
      end
    end
    if (bad) ramstate = ERROR;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      lren_q    <= 1'b0;
      lwen_q    <= 1'b0;
      laddr_q   <= 32'd0;
      naccess_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lren_q    <= lren_d;
      lwen_q    <= lwen_d;
      laddr_q   <= laddr_d;
      naccess_q <= naccess_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) mem[lidx] <= ramstore;
  end

  assign ramload = (ramstate == ACCESS && lren_q) ? mem[lidx] : 32'd0;
  assign naccess = naccess_q;

endmodule

// File: tb/tb_ram_latency_model.sv
// Directed bench for ram_latency_model: LAT=2 main instance plus LAT=1 and LAT=15 instances on shared inputs.
module tb_ram_latency_model;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ren = 1'b0, wen = 1'b0;
  logic [31:0] addr = 32'd0, wdat = 32'd0;
  logic [31:0] load2, load1, load15, na2, na1, na15;
  logic [1:0]  st2, st1, st15;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ram_latency_model #(.LAT(2), .ADDR_W(10)) u_dut (
    .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr), .ramstore(wdat),
    .ramload(load2), .ramstate(st2), .naccess(na2));
  ram_latency_model #(.LAT(1), .ADDR_W(10)) u_lat1 (
    .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr), .ramstore(wdat),
    .ramload(load1), .ramstate(st1), .naccess(na1));
  ram_latency_model #(.LAT(15), .ADDR_W(10)) u_lat15 (
    .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr), .ramstore(wdat),
    .ramload(load15), .ramstate(st15), .naccess(na15));

  // One cycle of stimulus: inputs change on the falling edge, outputs are sampled 1 time unit later.
  task automatic drive(input logic r_rst, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    RST = r_rst; ren = r; wen = w; addr = a; wdat = d;
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (st2 !== FREE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", st2, FREE); end
    checks++; if (load2 !== 32'd0) begin errors++; $display("FAIL reset_load got=%h exp=0", load2); end
    checks++; if (na2 !== 32'd0) begin errors++; $display("FAIL reset_naccess got=%0d exp=0", na2); end
    checks++; if (na1 !== 32'd0 || na15 !== 32'd0) begin
      errors++; $display("FAIL reset_naccess_lat got=%0d/%0d exp=0/0", na1, na15);
    end
  endtask

  task automatic test_write_read;
    logic [1:0]  es;
    logic [31:0] el;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
      es = (c == 2) ? ACCESS : BUSY;
      checks++; if (st2 !== es) begin errors++; $display("FAIL wr_state c=%0d got=%0d exp=%0d", c, st2, es); end
      checks++; if (load2 !== 32'd0) begin errors++; $display("FAIL wr_load c=%0d got=%h exp=0", c, load2); end
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
      es = (c == 2) ? ACCESS : BUSY;
      el = (c == 2) ? 32'hDEADBEEF : 32'd0;
      checks++; if (st2 !== es) begin errors++; $display("FAIL rd_state c=%0d got=%0d exp=%0d", c, st2, es); end
      checks++; if (load2 !== el) begin errors++; $display("FAIL rd_load c=%0d got=%h exp=%h", c, load2, el); end
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (st2 !== FREE) begin errors++; $display("FAIL rd_free got=%0d exp=%0d", st2, FREE); end
    checks++; if (na2 !== 32'd2) begin errors++; $display("FAIL wr_rd_naccess got=%0d exp=2", na2); end
  endtask

  task automatic test_error;
    logic [1:0] es;
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h12345678);
      checks++; if (st2 !== ERROR) begin errors++; $display("FAIL both_err c=%0d got=%0d exp=%0d", c, st2, ERROR); end
      checks++; if (load2 !== 32'd0) begin errors++; $display("FAIL both_load c=%0d got=%h exp=0", c, load2); end
    end
    checks++; if (na2 !== 32'd2) begin errors++; $display("FAIL both_naccess got=%0d exp=2", na2); end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h12345678);
      es = (c == 2) ? ACCESS : BUSY;
      checks++; if (st2 !== es) begin errors++; $display("FAIL err_rd_state c=%0d got=%0d exp=%0d", c, st2, es); end
    end
    checks++; if (load2 !== 32'hDEADBEEF) begin errors++; $display("FAIL err_nowrite got=%h exp=deadbeef", load2); end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (na2 !== 32'd3) begin errors++; $display("FAIL err_naccess got=%0d exp=3", na2); end
  endtask

  task automatic test_addr_change;
    logic [1:0]  es;
    logic [31:0] el;
    for (int c = 0; c < 3; c++) drive(1'b0, 1'b0, 1'b1, 32'h44, 32'hA5A5A5A5);
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
    checks++; if (st2 !== BUSY) begin errors++; $display("FAIL chg_c0 got=%0d exp=%0d", st2, BUSY); end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h44, 32'd0);
      es = (c == 2) ? ACCESS : BUSY;
      el = (c == 2) ? 32'hA5A5A5A5 : 32'd0;
      checks++; if (st2 !== es) begin errors++; $display("FAIL chg_state c=%0d got=%0d exp=%0d", c + 1, st2, es); end
      checks++; if (load2 !== el) begin errors++; $display("FAIL chg_load c=%0d got=%h exp=%h", c + 1, load2, el); end
    end
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h55555555);
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h55555555);
    drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h55555555);
    checks++; if (st2 !== BUSY) begin errors++; $display("FAIL abort_done got=%0d exp=%0d", st2, BUSY); end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (st2 !== FREE) begin errors++; $display("FAIL abort_free got=%0d exp=%0d", st2, FREE); end
    checks++; if (na2 !== 32'd5) begin errors++; $display("FAIL abort_naccess got=%0d exp=5", na2); end
    for (int c = 0; c < 3; c++) drive(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
    checks++; if (load2 !== 32'hDEADBEEF) begin errors++; $display("FAIL abort_mem got=%h exp=deadbeef", load2); end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (na2 !== 32'd6) begin errors++; $display("FAIL chg_naccess got=%0d exp=6", na2); end
  endtask

  task automatic test_range_reset;
    drive(1'b0, 1'b1, 1'b0, 32'h1000, 32'd0);
    checks++; if (st2 !== ERROR) begin errors++; $display("FAIL range_err got=%0d exp=%0d", st2, ERROR); end
    checks++; if (load2 !== 32'd0) begin errors++; $display("FAIL range_load got=%h exp=0", load2); end
    drive(1'b0, 1'b0, 1'b1, 32'h8000_0040, 32'h1);
    checks++; if (st2 !== ERROR) begin errors++; $display("FAIL range_err_hi got=%0d exp=%0d", st2, ERROR); end
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h0BAD0BAD);
    drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h0BAD0BAD);
    checks++; if (st2 !== BUSY) begin errors++; $display("FAIL rst_wait_state got=%0d exp=%0d", st2, BUSY); end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (st2 !== FREE) begin errors++; $display("FAIL rst_wait_free got=%0d exp=%0d", st2, FREE); end
    checks++; if (na2 !== 32'd0) begin errors++; $display("FAIL rst_wait_naccess got=%0d exp=0", na2); end
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h0BAD0BAD);
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h0BAD0BAD);
    drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h0BAD0BAD);
    checks++; if (st2 !== ACCESS) begin errors++; $display("FAIL rst_done_state got=%0d exp=%0d", st2, ACCESS); end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (na2 !== 32'd0) begin errors++; $display("FAIL rst_done_naccess got=%0d exp=0", na2); end
    for (int c = 0; c < 3; c++) drive(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
    checks++; if (load2 !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_nowrite got=%h exp=deadbeef", load2); end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (na2 !== 32'd1) begin errors++; $display("FAIL rst_rd_naccess got=%0d exp=1", na2); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  e1, e2, e15;
    logic [31:0] l1, l2, l15;
    // 16 held cycles cover at least one completed write in every build.
    for (int c = 0; c < 16; c++) drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h600DF00D);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int c = 0; c < 32; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
      e1  = ((c % 2)  == 1)  ? ACCESS : BUSY;
      e2  = ((c % 3)  == 2)  ? ACCESS : BUSY;
      e15 = ((c % 16) == 15) ? ACCESS : BUSY;
      l1  = (e1  == ACCESS) ? 32'h600DF00D : 32'd0;
      l2  = (e2  == ACCESS) ? 32'h600DF00D : 32'd0;
      l15 = (e15 == ACCESS) ? 32'h600DF00D : 32'd0;
      checks++; if (st1 !== e1) begin errors++; $display("FAIL b2b_lat1_state c=%0d got=%0d exp=%0d", c, st1, e1); end
      checks++; if (st2 !== e2) begin errors++; $display("FAIL b2b_lat2_state c=%0d got=%0d exp=%0d", c, st2, e2); end
      checks++; if (st15 !== e15) begin errors++; $display("FAIL b2b_lat15_state c=%0d got=%0d exp=%0d", c, st15, e15); end
      checks++; if (load1 !== l1) begin errors++; $display("FAIL b2b_lat1_load c=%0d got=%h exp=%h", c, load1, l1); end
      checks++; if (load2 !== l2) begin errors++; $display("FAIL b2b_lat2_load c=%0d got=%h exp=%h", c, load2, l2); end
      checks++; if (load15 !== l15) begin errors++; $display("FAIL b2b_lat15_load c=%0d got=%h exp=%h", c, load15, l15); end
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (na1 !== 32'd16) begin errors++; $display("FAIL b2b_lat1_naccess got=%0d exp=16", na1); end
    checks++; if (na2 !== 32'd10) begin errors++; $display("FAIL b2b_lat2_naccess got=%0d exp=10", na2); end
    checks++; if (na15 !== 32'd2) begin errors++; $display("FAIL b2b_lat15_naccess got=%0d exp=2", na15); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_error;
    test_addr_change;
    test_range_reset;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
